// File: rtl/tree_vote_engine_if.sv
// Bus bundle for tree_vote_engine: request/leaf inputs and result outputs.
// Optional margin output is present only when VOTE_MARGIN_EN is defined.
// Handshake: start is a level sampled every clock; it arms a pending request
// that is served on the first edge where every tree_done bit is high and the
// engine is idle. done is a one-cycle pulse; results hold until the next done.
interface tree_vote_engine_if #(
   parameter int N_TREES = 16,
   parameter int CNT_W   = $clog2(N_TREES + 1),
   parameter int SUM_W   = 32 + $clog2(N_TREES)
);
   logic                   start;
   logic                   mode;
   logic [N_TREES*32-1:0]  leaf_vals;
   logic [N_TREES-1:0]     tree_done;
   logic [7:0]             prediction;
   logic [CNT_W-1:0]       votes;
   logic [SUM_W-1:0]       sum;
   logic [CNT_W-1:0]       invalid_cnt;
   logic                   done;
   logic                   busy;
   logic                   idle_sys;
   logic [1:0]             dbg_state;
`ifdef VOTE_MARGIN_EN
   logic [CNT_W-1:0]       margin;
`endif

   modport master (
      output start, mode, leaf_vals, tree_done,
      input  prediction, votes, sum, invalid_cnt, done, busy, idle_sys, dbg_state
`ifdef VOTE_MARGIN_EN
      , input margin
`endif
   );

   modport slave (
      input  start, mode, leaf_vals, tree_done,
      output prediction, votes, sum, invalid_cnt, done, busy, idle_sys, dbg_state
`ifdef VOTE_MARGIN_EN
      , output margin
`endif
   );
endinterface

// File: rtl/tree_vote_engine.sv
// Ensemble combiner: snapshots all tree leaves once every tree is done, then
// either counts class votes (LANES trees per cycle, then a per-class scan with
// lowest-index tie-break) or sums sign-extended leaves. Result is reported
// with a single-cycle done pulse. Optional macro VOTE_MARGIN_EN adds a
// winner-minus-runner-up margin output.
module tree_vote_engine #(
   parameter int N_TREES   = 16,
   parameter int N_CLASSES = 32,
   parameter int LANES     = 1,
   parameter int CNT_W     = $clog2(N_TREES + 1),
   parameter int SUM_W     = 32 + $clog2(N_TREES)
) (
   input logic               clk,
   input logic               rst_n,
   tree_vote_engine_if.slave bus
);
   localparam int N_GROUPS = N_TREES / LANES;
   localparam int GRP_W    = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
   localparam int CLS_W    = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_COUNT, S_SCAN, S_DONE} state_t;

   state_t                 r_state;
   logic                   r_pending;
   logic                   r_mode;
   logic [N_TREES*32-1:0]  r_snap;
   logic [GRP_W-1:0]       r_grp;
   logic [CLS_W-1:0]       r_scan;
   logic [CNT_W-1:0]       r_cnt [N_CLASSES];
   logic [CNT_W-1:0]       r_inv;
   logic [SUM_W-1:0]       r_sum;
   logic [CLS_W-1:0]       r_best_idx;
   logic [CNT_W-1:0]       r_best_cnt;
   logic [7:0]             r_prediction;
   logic [CNT_W-1:0]       r_votes;
   logic [SUM_W-1:0]       r_sum_out;
   logic [CNT_W-1:0]       r_inv_out;
   logic                   r_done;
   logic                   r_busy;
   logic                   r_idle;
`ifdef VOTE_MARGIN_EN
   logic [CNT_W-1:0]       r_second_cnt;
   logic [CNT_W-1:0]       r_margin;
`endif

   logic [31:0]            w_lane [LANES];
   logic [CNT_W-1:0]       w_cnt_nxt [N_CLASSES];
   logic [CNT_W-1:0]       w_inv_nxt;
   logic [SUM_W-1:0]       w_sum_nxt;

   // Lane datapath: apply this cycle's group of leaves to the running totals.
   // Lanes are folded sequentially so several hits on one class all count.
   always_comb begin
      w_cnt_nxt = r_cnt;
      w_inv_nxt = r_inv;
      w_sum_nxt = r_sum;
      for (int l = 0; l < LANES; l++) begin
         w_lane[l] = r_snap[(int'(r_grp) * LANES + l) * 32 +: 32];
         if (r_mode) begin
            w_sum_nxt = w_sum_nxt + {{(SUM_W-32){w_lane[l][31]}}, w_lane[l]};
         end else if (w_lane[l] < 32'(N_CLASSES)) begin
            w_cnt_nxt[w_lane[l][CLS_W-1:0]] = w_cnt_nxt[w_lane[l][CLS_W-1:0]] + CNT_W'(1);
         end else begin
            w_inv_nxt = w_inv_nxt + CNT_W'(1);
         end
      end
   end

   // Control FSM with registered result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_pending    <= 1'b0;
         r_mode       <= 1'b0;
         r_snap       <= '0;
         r_grp        <= '0;
         r_scan       <= '0;
         for (int c = 0; c < N_CLASSES; c++) r_cnt[c] <= '0;
         r_inv        <= '0;
         r_sum        <= '0;
         r_best_idx   <= '0;
         r_best_cnt   <= '0;
         r_prediction <= '0;
         r_votes      <= '0;
         r_sum_out    <= '0;
         r_inv_out    <= '0;
         r_done       <= 1'b0;
         r_busy       <= 1'b0;
         r_idle       <= 1'b1;
`ifdef VOTE_MARGIN_EN
         r_second_cnt <= '0;
         r_margin     <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         if (bus.start) r_pending <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (r_pending && (&bus.tree_done)) begin
                  // Capture clears pending, so a start in this same cycle is absorbed.
                  r_snap    <= bus.leaf_vals;
                  r_mode    <= bus.mode;
                  for (int c = 0; c < N_CLASSES; c++) r_cnt[c] <= '0;
                  r_inv     <= '0;
                  r_sum     <= '0;
                  r_grp     <= '0;
                  r_pending <= 1'b0;
                  r_busy    <= 1'b1;
                  r_idle    <= 1'b0;
                  r_state   <= S_COUNT;
               end
            end
            S_COUNT: begin
               r_cnt <= w_cnt_nxt;
               r_inv <= w_inv_nxt;
               r_sum <= w_sum_nxt;
               r_grp <= r_grp + GRP_W'(1);
               if (r_grp == GRP_W'(N_GROUPS - 1)) begin
                  r_scan     <= '0;
                  r_best_idx <= '0;
                  r_best_cnt <= '0;
`ifdef VOTE_MARGIN_EN
                  r_second_cnt <= '0;
`endif
                  r_state    <= r_mode ? S_DONE : S_SCAN;
               end
            end
            S_SCAN: begin
               // Strictly-greater replacement keeps the lowest index on ties.
               if (r_cnt[r_scan] > r_best_cnt) begin
                  r_best_cnt <= r_cnt[r_scan];
                  r_best_idx <= r_scan;
               end
`ifdef VOTE_MARGIN_EN
               if (r_cnt[r_scan] > r_best_cnt) r_second_cnt <= r_best_cnt;
               else if (r_cnt[r_scan] > r_second_cnt) r_second_cnt <= r_cnt[r_scan];
`endif
               r_scan <= r_scan + CLS_W'(1);
               if (r_scan == CLS_W'(N_CLASSES - 1)) r_state <= S_DONE;
            end
            S_DONE: begin
               if (r_mode) begin
                  r_prediction <= '0;
                  r_votes      <= '0;
                  r_sum_out    <= r_sum;
                  r_inv_out    <= '0;
`ifdef VOTE_MARGIN_EN
                  r_margin     <= '0;
`endif
               end else begin
                  r_prediction <= 8'(r_best_idx);
                  r_votes      <= r_best_cnt;
                  r_sum_out    <= '0;
                  r_inv_out    <= r_inv;
`ifdef VOTE_MARGIN_EN
                  r_margin     <= r_best_cnt - r_second_cnt;
`endif
               end
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_idle  <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.prediction  = r_prediction;
   assign bus.votes       = r_votes;
   assign bus.sum         = r_sum_out;
   assign bus.invalid_cnt = r_inv_out;
   assign bus.done        = r_done;
   assign bus.busy        = r_busy;
   assign bus.idle_sys    = r_idle;
   assign bus.dbg_state   = r_state;
`ifdef VOTE_MARGIN_EN
   assign bus.margin      = r_margin;
`endif
endmodule

// File: tb/tb_tree_vote_engine.sv
// Bench for tree_vote_engine: two instances (LANES=1 and LANES=4) share one
// stimulus stream; each result is compared against a counting/sorting model.
module tb_tree_vote_engine;
   localparam int N_TREES   = 16;
   localparam int N_CLASSES = 32;
   localparam int CNT_W     = $clog2(N_TREES + 1);
   localparam int SUM_W     = 32 + $clog2(N_TREES);
   localparam int LANES_A   = 1;
   localparam int LANES_B   = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic                  start = 1'b0;
   logic                  mode = 1'b0;
   logic [N_TREES*32-1:0] leaf_vals = '0;
   logic [N_TREES-1:0]    tree_done = '0;
   logic [31:0]           lv [N_TREES];

   tree_vote_engine_if #(.N_TREES(N_TREES), .CNT_W(CNT_W), .SUM_W(SUM_W)) if_a ();
   tree_vote_engine_if #(.N_TREES(N_TREES), .CNT_W(CNT_W), .SUM_W(SUM_W)) if_b ();

   tree_vote_engine #(.N_TREES(N_TREES), .N_CLASSES(N_CLASSES), .LANES(LANES_A),
                      .CNT_W(CNT_W), .SUM_W(SUM_W))
      dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
   tree_vote_engine #(.N_TREES(N_TREES), .N_CLASSES(N_CLASSES), .LANES(LANES_B),
                      .CNT_W(CNT_W), .SUM_W(SUM_W))
      dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

   assign if_a.start = start;     assign if_b.start = start;
   assign if_a.mode = mode;       assign if_b.mode = mode;
   assign if_a.leaf_vals = leaf_vals; assign if_b.leaf_vals = leaf_vals;
   assign if_a.tree_done = tree_done; assign if_b.tree_done = tree_done;

   logic [7:0]       o_pred  [2];
   logic [CNT_W-1:0] o_votes [2];
   logic [SUM_W-1:0] o_sum   [2];
   logic [CNT_W-1:0] o_inv   [2];
   logic             o_done  [2];
   logic             o_busy  [2];
   logic             o_idle  [2];
   assign o_pred[0] = if_a.prediction;  assign o_pred[1] = if_b.prediction;
   assign o_votes[0] = if_a.votes;      assign o_votes[1] = if_b.votes;
   assign o_sum[0] = if_a.sum;          assign o_sum[1] = if_b.sum;
   assign o_inv[0] = if_a.invalid_cnt;  assign o_inv[1] = if_b.invalid_cnt;
   assign o_done[0] = if_a.done;        assign o_done[1] = if_b.done;
   assign o_busy[0] = if_a.busy;        assign o_busy[1] = if_b.busy;
   assign o_idle[0] = if_a.idle_sys;    assign o_idle[1] = if_b.idle_sys;
`ifdef VOTE_MARGIN_EN
   logic [CNT_W-1:0] o_margin [2];
   assign o_margin[0] = if_a.margin;    assign o_margin[1] = if_b.margin;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // expected result of the current inference
   bit         exp_mode;
   int         exp_pred, exp_votes, exp_inv, exp_margin;
   logic [SUM_W-1:0] exp_sum;
   int         lanes_of [2] = '{LANES_A, LANES_B};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: histogram, sort counts descending, pick lowest index with max.
   function automatic void model(input bit md);
      int cnt [N_CLASSES];
      int q [$];
      longint s;
      exp_mode = md;
      exp_pred = 0; exp_votes = 0; exp_inv = 0; exp_margin = 0; exp_sum = '0;
      if (md) begin
         s = 0;
         for (int t = 0; t < N_TREES; t++) s += longint'($signed(lv[t]));
         exp_sum = s[SUM_W-1:0];
      end else begin
         for (int c = 0; c < N_CLASSES; c++) cnt[c] = 0;
         for (int t = 0; t < N_TREES; t++) begin
            if (lv[t] < N_CLASSES) cnt[lv[t]]++;
            else exp_inv++;
         end
         for (int c = 0; c < N_CLASSES; c++) q.push_back(cnt[c]);
         q.rsort();
         exp_votes  = q[0];
         exp_margin = q[0] - q[1];
         for (int c = N_CLASSES - 1; c >= 0; c--) if (cnt[c] == exp_votes) exp_pred = c;
      end
   endfunction

   function automatic int latency(input int d);
      return exp_mode ? (N_TREES / lanes_of[d] + 1)
                      : (N_TREES / lanes_of[d] + N_CLASSES + 1);
   endfunction

   task automatic shuffle();
      logic [31:0] tmp;
      int j;
      for (int i = N_TREES - 1; i > 0; i--) begin
         j = $urandom_range(0, i);
         tmp = lv[i]; lv[i] = lv[j]; lv[j] = tmp;
      end
   endtask

   task automatic set_two(input int a, input int na, input int b);
      for (int t = 0; t < N_TREES; t++) lv[t] = (t < na) ? 32'(a) : 32'(b);
      shuffle();
   endtask

   task automatic check_result(input int d, input string tag);
      chk({tag, "/pred"},  64'(o_pred[d]),  64'(exp_pred));
      chk({tag, "/votes"}, 64'(o_votes[d]), 64'(exp_votes));
      chk({tag, "/sum"},   64'(o_sum[d]),   64'(exp_sum));
      chk({tag, "/inv"},   64'(o_inv[d]),   64'(exp_inv));
`ifdef VOTE_MARGIN_EN
      chk({tag, "/margin"}, 64'(o_margin[d]), 64'(exp_margin));
`endif
   endtask

   // Start pulse with all trees done; returns #1 after the capture edge.
   task automatic launch(input bit md);
      @(negedge clk);
      mode = md;
      for (int t = 0; t < N_TREES; t++) leaf_vals[t*32 +: 32] = lv[t];
      tree_done = '1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
      model(md);
   endtask

   // Observe both instances until their done pulse(s); check timing and data.
   task automatic watch(input string tag, input bit scramble, input bit extra_start);
      int first_lat [2];
      int n_done [2];
      int nmax;
      string dt;
      for (int d = 0; d < 2; d++) begin
         dt = $sformatf("%s/d%0d", tag, d);
         first_lat[d] = latency(d);
         n_done[d] = 0;
         chk({dt, "/busy_cap"}, 64'(o_busy[d]), 64'd1);
         chk({dt, "/idle_cap"}, 64'(o_idle[d]), 64'd0);
      end
      nmax = (extra_start ? 2 * first_lat[0] + 1 : first_lat[0]) + 3;
      for (int cyc = 1; cyc <= nmax; cyc++) begin
         @(negedge clk);
         if (scramble) begin
            leaf_vals = {N_TREES{$urandom()}};
            tree_done = N_TREES'($urandom());
            mode = 1'($urandom());
         end
         start = (extra_start && cyc == 3);
         @(posedge clk); #1;
         for (int d = 0; d < 2; d++) begin
            dt = $sformatf("%s/d%0d", tag, d);
            if (o_done[d]) begin
               n_done[d]++;
               chk({dt, "/done_cycle"}, 64'(cyc),
                   64'((n_done[d] == 1) ? first_lat[d] : 2 * first_lat[d] + 1));
               check_result(d, dt);
               chk({dt, "/busy_done"}, 64'(o_busy[d]), 64'd0);
               chk({dt, "/idle_done"}, 64'(o_idle[d]), 64'd1);
            end
            if (extra_start && cyc == first_lat[d] + 1)
               chk({dt, "/busy_requeue"}, 64'(o_busy[d]), 64'd1);
         end
      end
      start = 1'b0;
      for (int d = 0; d < 2; d++) begin
         dt = $sformatf("%s/d%0d", tag, d);
         chk({dt, "/done_count"}, 64'(n_done[d]), 64'(extra_start ? 2 : 1));
         check_result(d, {dt, "/hold"});
      end
   endtask

   task automatic check_reset_state(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s/d%0d/pred", tag, d),  64'(o_pred[d]),  64'd0);
         chk($sformatf("%s/d%0d/votes", tag, d), 64'(o_votes[d]), 64'd0);
         chk($sformatf("%s/d%0d/sum", tag, d),   64'(o_sum[d]),   64'd0);
         chk($sformatf("%s/d%0d/inv", tag, d),   64'(o_inv[d]),   64'd0);
         chk($sformatf("%s/d%0d/done", tag, d),  64'(o_done[d]),  64'd0);
         chk($sformatf("%s/d%0d/busy", tag, d),  64'(o_busy[d]),  64'd0);
         chk($sformatf("%s/d%0d/idle", tag, d),  64'(o_idle[d]),  64'd1);
`ifdef VOTE_MARGIN_EN
         chk($sformatf("%s/d%0d/margin", tag, d), 64'(o_margin[d]), 64'd0);
`endif
      end
   endtask

   initial begin
      // reset
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // majority: 3 x9, 5 x7
      set_two(3, 9, 5);
      launch(1'b0);
      watch("maj_3v5", 1'b1, 1'b0);

      // tie resolves to lowest index
      set_two(7, 8, 2);
      launch(1'b0);
      watch("tie", 1'b0, 1'b0);

      // invalid leaves mixed with valid
      set_two(40, 4, 1);
      launch(1'b0);
      watch("inv_mix", 1'b0, 1'b0);

      // class boundary: 31 valid, 32 invalid
      for (int t = 0; t < N_TREES; t++) lv[t] = (t < 8) ? 32'd31 : (t < 11) ? 32'd32 : 32'd0;
      shuffle();
      launch(1'b0);
      watch("boundary", 1'b1, 1'b0);

      // all invalid
      for (int t = 0; t < N_TREES; t++) lv[t] = $urandom_range(N_CLASSES, 1000) | ((t % 3 == 0) ? 32'h8000_0000 : 32'h0);
      launch(1'b0);
      watch("all_inv", 1'b0, 1'b0);

      // regression alternating extremes
      for (int t = 0; t < N_TREES; t++) lv[t] = (t % 2 == 0) ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
      launch(1'b1);
      watch("reg_alt", 1'b1, 1'b0);

      // all leaves equal: several lanes hit one class in a cycle
      for (int t = 0; t < N_TREES; t++) lv[t] = 32'd6;
      launch(1'b0);
      watch("all6", 1'b0, 1'b0);

      // randomized majority and regression
      for (int r = 0; r < 8; r++) begin
         for (int t = 0; t < N_TREES; t++)
            lv[t] = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 5 + r * 3));
         launch(1'b0);
         watch($sformatf("rnd_maj%0d", r), r[0], 1'b0);
      end
      for (int r = 0; r < 4; r++) begin
         for (int t = 0; t < N_TREES; t++) lv[t] = $urandom();
         launch(1'b1);
         watch($sformatf("rnd_reg%0d", r), r[0], 1'b0);
      end

      // reset during SCAN aborts without done
      for (int t = 0; t < N_TREES; t++) lv[t] = 32'($urandom_range(1, 4));
      launch(1'b0);
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(posedge clk); #1;
         chk($sformatf("pre_abort/c%0d/done_a", cyc), 64'(o_done[0]), 64'd0);
         chk($sformatf("pre_abort/c%0d/done_b", cyc), 64'(o_done[1]), 64'd0);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_state("abort");
      repeat (3) begin
         @(posedge clk); #1;
         chk("abort_hold/done_a", 64'(o_done[0]), 64'd0);
         chk("abort_hold/done_b", 64'(o_done[1]), 64'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int t = 0; t < N_TREES; t++) lv[t] = 32'($urandom_range(0, 3));
      launch(1'b0);
      watch("after_abort", 1'b0, 1'b0);

      // start while busy queues exactly one more inference
      for (int t = 0; t < N_TREES; t++) lv[t] = 32'($urandom_range(8, 12));
      launch(1'b0);
      watch("requeue_maj", 1'b0, 1'b1);
      for (int t = 0; t < N_TREES; t++) lv[t] = $urandom();
      launch(1'b1);
      watch("requeue_reg", 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
